// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI encodings, write-master state enum and the AxSIZE helper
package axi_pkg;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/axi_beat_ctr.sv
// axi_beat_ctr: counts W handshakes within a burst and flags the last beat
module axi_beat_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       last
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? 8'd0 : inc ? cnt + 8'd1 : cnt;
  assign last = cnt == len;
endmodule

// File: rtl/axi_wr_master.sv
// axi_wr_master: issues one INCR burst per command on AW/W, collects B, and
// aborts with a SLVERR-coded done if any channel stalls for TIMEOUT cycles.
module axi_wr_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT    = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic [2:0]              axi_awsize,
  output logic [1:0]              axi_awburst,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    done_timeout
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic accept, aw_hs, w_hs, b_hs, tmo, last;
  assign accept      = state == IDLE && cmd_valid && cmd_ready;
  assign aw_hs       = axi_awvalid && axi_awready;
  assign axi_wvalid  = state == DATA && wr_valid;
  assign wr_ready    = state == DATA && axi_wready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign b_hs        = axi_bready && axi_bvalid;
  assign axi_wlast   = state == DATA && last;
  assign axi_wdata   = wr_data;
  assign axi_wstrb   = wr_strb;
  assign axi_awsize  = axi_size(DATA_WIDTH);
  assign axi_awburst = BURST_INCR;
  // A handshake in the expiry cycle takes priority over the abort
  assign tmo = state != IDLE && !(aw_hs || w_hs || b_hs) && wait_cnt == WW'(TIMEOUT - 1);
  axi_beat_ctr u_beat_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (w_hs),
    .len   (axi_awlen),
    .last  (last)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = tmo ? IDLE :
                accept ? ADDR :
                aw_hs ? DATA :
                (w_hs && axi_wlast) ? RESP :
                b_hs ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      axi_awvalid  <= 1'b0;
      axi_awaddr   <= '0;
      axi_awlen    <= '0;
      axi_bready   <= 1'b0;
      wait_cnt     <= '0;
      done         <= 1'b0;
      done_resp    <= RESP_OKAY;
      done_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= state == IDLE && state_nxt == IDLE;
      axi_awvalid <= accept || (axi_awvalid && !aw_hs && !tmo);
      axi_bready  <= (w_hs && axi_wlast) || (axi_bready && !b_hs && !tmo);
      wait_cnt    <= (state == IDLE || state_nxt != state || aw_hs || w_hs || b_hs) ? '0 : wait_cnt + 1'b1;
      done        <= b_hs || tmo;
      if (accept) begin
        axi_awaddr <= cmd_addr;
        axi_awlen  <= cmd_len;
      end
      if (b_hs) begin
        done_resp    <= axi_bresp;
        done_timeout <= 1'b0;
      end else if (tmo) begin
        done_resp    <= RESP_SLVERR;
        done_timeout <= 1'b1;
      end
    end
endmodule

// File: tb/tb_axi_wr_master.sv
// tb_axi_wr_master: scoreboard bench with a configurable AXI slave and data stream
module tb_axi_wr_master;
  localparam int TIMEOUT = 100;
  typedef struct {logic [127:0] d; logic [15:0] s; logic l;} beat_t;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic wr_valid = 0, wr_ready;
  logic [127:0] wr_data = 0;
  logic [15:0] wr_strb = 0;
  logic axi_awvalid, axi_awready = 0;
  logic [31:0] axi_awaddr;
  logic [7:0] axi_awlen;
  logic [2:0] axi_awsize;
  logic [1:0] axi_awburst;
  logic axi_wvalid, axi_wready = 0, axi_wlast;
  logic [127:0] axi_wdata;
  logic [15:0] axi_wstrb;
  logic axi_bvalid = 0, axi_bready;
  logic [1:0] axi_bresp = 0;
  logic done, done_timeout;
  logic [1:0] done_resp;
  int n_tests = 0, n_fail = 0;
  beat_t stream[$], exp_w[$];
  logic [39:0] exp_aw[$];
  logic [2:0] exp_done[$];
  int aw_stall = 0, w_stall_beat = -1, stall_left = 0, b_delay = 0;
  logic [1:0] bresp_val = 2'b00;
  logic wready_on = 1;
  int aw_cnt = 0, b_cnt = 0, wbeats = 0, bw = 0, cyc = 0;
  logic w_took = 0, done_seen = 0, prev_stall = 0;
  logic [31:0] prev_addr;
  logic [7:0] prev_len;

  axi_wr_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_strb(wr_strb), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .done(done), .done_resp(done_resp), .done_timeout(done_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [39:0] a;
    logic [2:0] dn;
    beat_t b;
    cyc++;
    if (prev_stall) begin
      chk("aw_hold", axi_awvalid, 1);
      chk("aw_addr_stable", axi_awaddr, prev_addr);
      chk("aw_len_stable", axi_awlen, prev_len);
    end
    prev_stall = axi_awvalid && !axi_awready;
    prev_addr = axi_awaddr;
    prev_len = axi_awlen;
    if (axi_awvalid) chk("w_before_aw", axi_wvalid, 0);
    if (axi_awvalid && axi_awready) begin
      cyc = 0;
      if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
      else begin
        a = exp_aw.pop_front();
        chk("awaddr", axi_awaddr, a[39:8]);
        chk("awlen", axi_awlen, a[7:0]);
        chk("awsize", axi_awsize, 3'd4);
        chk("awburst", axi_awburst, 2'b01);
      end
    end
    w_took = axi_wvalid && axi_wready;
    if (w_took) begin
      wbeats++;
      if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        b = exp_w.pop_front();
        chk("wdata", axi_wdata, b.d);
        chk("wstrb", axi_wstrb, b.s);
        chk("wlast", axi_wlast, b.l);
      end
    end
    if (axi_bready && !axi_bvalid) bw++;
    if (axi_bready && axi_bvalid) begin
      chk("b_wait", bw, b_delay);
      bw = 0;
    end
    if (done) begin
      done_seen = 1;
      chk("rdy_during_done", cmd_ready, 0);
      if (done_timeout) chk("tmo_cycle", cyc, TIMEOUT + 1);
      if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        dn = exp_done.pop_front();
        chk("done_resp", done_resp, dn[2:1]);
        chk("done_timeout", done_timeout, dn[0]);
      end
    end
  end

  always @(posedge clk) begin
    beat_t b;
    #1;
    if (w_took && stream.size() > 0) b = stream.pop_front();
    wr_valid = stream.size() > 0;
    if (wr_valid) begin
      wr_data = stream[0].d;
      wr_strb = stream[0].s;
    end
    axi_awready = axi_awvalid && aw_cnt >= aw_stall;
    aw_cnt = axi_awvalid ? aw_cnt + 1 : 0;
    if (wbeats == w_stall_beat && stall_left > 0) begin
      axi_wready = 0;
      stall_left--;
    end else axi_wready = wready_on;
    axi_bvalid = axi_bready && b_cnt >= b_delay;
    axi_bresp = bresp_val;
    b_cnt = axi_bready ? b_cnt + 1 : 0;
  end

  task automatic burst(input logic [31:0] a, input logic [7:0] l, input logic [127:0] d0,
                       input logic [1:0] resp, input logic tmo, input logic wait_done);
    int k;
    beat_t b;
    exp_aw.push_back({a, l});
    for (int i = 0; i <= int'(l); i++) begin
      b.d = (i == 0) ? d0 : {$urandom, $urandom, $urandom, $urandom};
      b.s = (i == 0) ? 16'hFFFF : 16'($urandom);
      b.l = i == int'(l);
      stream.push_back(b);
      if (!tmo) exp_w.push_back(b);
    end
    exp_done.push_back({resp, tmo});
    wbeats = 0;
    done_seen = 0;
    k = 0;
    while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!cmd_ready) chk("cmd_ready_wait", 0, 1);
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    if (wait_done) begin
      k = 0;
      while (!done_seen && k < 400) begin @(posedge clk); #1; k++; end
      if (!done_seen) chk("done_wait", 0, 1);
      chk("rdy_after_done", cmd_ready, 1);
      chk("queues_empty", exp_aw.size() + exp_w.size() + exp_done.size(), 0);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_wlast", axi_wlast, 0);
    chk("rst_awaddr", {axi_awaddr, axi_awlen}, 0);
    chk("rst_done", {done, done_resp, done_timeout}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("rdy_after_rst", cmd_ready, 1);

    burst(32'h1000, 8'd0, 128'h0123456789ABCDEF0123456789ABCDEF, 2'b00, 0, 1);
    chk("single_beats", wbeats, 1);

    w_stall_beat = 2; stall_left = 2;
    burst(32'h2040, 8'd3, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 2'b00, 0, 1);
    chk("burst4_beats", wbeats, 4);
    w_stall_beat = -1;

    aw_stall = 3;
    burst(32'h0000_8000, 8'd2, 128'h1, 2'b00, 0, 1);
    chk("awstall_beats", wbeats, 3);
    aw_stall = 0;

    b_delay = 5; bresp_val = 2'b10;
    burst(32'h4000, 8'd1, 128'h2, 2'b10, 0, 1);
    b_delay = 0; bresp_val = 2'b00;

    wready_on = 0;
    burst(32'h5000, 8'd0, 128'h3, 2'b10, 1, 1);
    chk("tmo_beats", wbeats, 0);
    stream.delete();
    wready_on = 1;

    burst(32'h6000, 8'd3, 128'h4, 2'b00, 0, 0);
    k = 0;
    while (wbeats < 2 && k < 100) begin @(posedge clk); #1; k++; end
    chk("reach_beat2", wbeats, 2);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_wlast}, 0);
    chk("rst_mid_ctrl", {cmd_ready, done, wr_ready}, 0);
    stream.delete(); exp_w.delete(); exp_aw.delete(); exp_done.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    burst(32'h3000, 8'd1, 128'hCAFE, 2'b00, 0, 1);
    chk("post_rst_beats", wbeats, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
